// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state encoding and constants for the
// sequential ALU with iterative multiply/divide.
package alu_pkg;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_NOR   = 4'b0100;
   localparam logic [3:0] OP_SLTU  = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_MULT  = 4'b1000;
   localparam logic [3:0] OP_MULTU = 4'b1001;
   localparam logic [3:0] OP_DIV   = 4'b1010;
   localparam logic [3:0] OP_DIVU  = 4'b1011;
   localparam logic [3:0] OP_MFHI  = 4'b1100;
   localparam logic [3:0] OP_MFLO  = 4'b1101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Quotient pattern for divide-by-zero; sliced to the operand width.
   localparam logic [127:0] DIVZERO_LO = '1;

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle unsigned engine: shift-add multiplier and restoring
// divider sharing a single WIDTH+1 adder. Operands are magnitudes.
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             done,
   output logic [WIDTH-1:0] hi_next,
   output logic [WIDTH-1:0] lo_next
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic             running;
   logic [CNT_W-1:0] cnt;
   logic             div_mode;
   logic [WIDTH-1:0] acc, q, opnd;
   logic [WIDTH-1:0] acc_nxt, q_nxt;
   logic [WIDTH:0]   shifted, add_x, add_y;
   logic             cin;
   logic [WIDTH+1:0] add_full;

   // Divide subtracts via x + ~y + 1; the carry out means "fits, keep difference".
   always_comb begin
      shifted = {acc, q[WIDTH-1]};
      if (div_mode) begin
         add_x = shifted;
         add_y = ~{1'b0, opnd};
         cin   = 1'b1;
      end else begin
         add_x = {1'b0, acc};
         add_y = q[0] ? {1'b0, opnd} : '0;
         cin   = 1'b0;
      end
      add_full = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, cin};
      if (div_mode) begin
         if (add_full[WIDTH+1]) begin
            acc_nxt = add_full[WIDTH-1:0];
            q_nxt   = {q[WIDTH-2:0], 1'b1};
         end else begin
            acc_nxt = shifted[WIDTH-1:0];
            q_nxt   = {q[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_nxt = add_full[WIDTH:1];
         q_nxt   = {add_full[0], q[WIDTH-1:1]};
      end
   end

   assign done    = running && (cnt == CNT_W'(WIDTH - 1));
   assign hi_next = acc_nxt;
   assign lo_next = q_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         running <= 1'b0;
         cnt     <= '0;
      end else if (start) begin
         running <= 1'b1;
         cnt     <= '0;
      end else if (running) begin
         cnt <= cnt + CNT_W'(1);
         if (done) running <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         acc      <= '0;
         q        <= op_a;
         opnd     <= op_b;
         div_mode <= is_div;
      end else if (running) begin
         acc <= acc_nxt;
         q   <= q_nxt;
      end
   end

endmodule

// File: rtl/alu_muldiv_seq.sv
// EX-stage ALU: single-cycle registered simple ops plus iterative
// MULT/DIV with architectural HI/LO, interlocked through in_ready.
module alu_muldiv_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OP_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy
);

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (~v) + WIDTH'(1) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] apply_sign2(input logic [2*WIDTH-1:0] v, input logic neg);
      return neg ? (~v) + (2*WIDTH)'(1) : v;
   endfunction

   state_t                  state;
   logic                    accept, is_md, is_signed, is_div, start;
   logic signed [WIDTH-1:0] a_sg, b_sg;
   logic [WIDTH-1:0]        sum_p0, diff_p0, res_p0, mag_a, mag_b;
   logic                    ovf_p0;
   logic                    md_done;
   logic [WIDTH-1:0]        md_hi, md_lo;
   logic                    neg_lo_s, neg_hi_s, dz_s;
   logic [WIDTH-1:0]        a_s;
   logic [2*WIDTH-1:0]      prod_fix;

   assign accept    = in_valid && in_ready;
   assign is_md     = (op == OP_W'(OP_MULT)) || (op == OP_W'(OP_MULTU)) ||
                      (op == OP_W'(OP_DIV))  || (op == OP_W'(OP_DIVU));
   assign is_signed = (op == OP_W'(OP_MULT)) || (op == OP_W'(OP_DIV));
   assign is_div    = (op == OP_W'(OP_DIV))  || (op == OP_W'(OP_DIVU));
   assign start     = accept && is_md;
   assign a_sg      = a;
   assign b_sg      = b;
   assign mag_a     = apply_sign(a, is_signed & a[WIDTH-1]);
   assign mag_b     = apply_sign(b, is_signed & b[WIDTH-1]);

   // Stage p0: combinational simple-op datapath, registered into result below.
   always_comb begin
      sum_p0  = a + b;
      diff_p0 = a - b;
      res_p0  = '0;
      ovf_p0  = 1'b0;
      case (op)
         OP_W'(OP_AND):  res_p0 = a & b;
         OP_W'(OP_OR):   res_p0 = a | b;
         OP_W'(OP_XOR):  res_p0 = a ^ b;
         OP_W'(OP_NOR):  res_p0 = ~(a | b);
         OP_W'(OP_ADD): begin
            res_p0 = sum_p0;
            ovf_p0 = (a[WIDTH-1] == b[WIDTH-1]) && (sum_p0[WIDTH-1] != a[WIDTH-1]);
         end
         OP_W'(OP_SUB): begin
            res_p0 = diff_p0;
            ovf_p0 = (a[WIDTH-1] != b[WIDTH-1]) && (diff_p0[WIDTH-1] != a[WIDTH-1]);
         end
         OP_W'(OP_SLT):  res_p0 = {{(WIDTH-1){1'b0}}, (a_sg < b_sg)};
         OP_W'(OP_SLTU): res_p0 = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_W'(OP_MFHI): res_p0 = hi;
         OP_W'(OP_MFLO): res_p0 = lo;
         default:        res_p0 = '0;
      endcase
   end

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .is_div  (is_div),
      .op_a    (mag_a),
      .op_b    (mag_b),
      .done    (md_done),
      .hi_next (md_hi),
      .lo_next (md_lo)
   );

   assign prod_fix = apply_sign2({md_hi, md_lo}, neg_lo_s);

   // Stage p1: FSM, output registers and HI/LO; sign fix-up lands with the last iteration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         overflow  <= 1'b0;
         hi        <= '0;
         lo        <= '0;
         neg_lo_s  <= 1'b0;
         neg_hi_s  <= 1'b0;
         dz_s      <= 1'b0;
         a_s       <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               state    <= ST_IDLE;
               in_ready <= 1'b1;
               if (accept) begin
                  if (is_md) begin
                     state    <= is_div ? ST_DIV : ST_MUL;
                     in_ready <= 1'b0;
                     busy     <= 1'b1;
                     neg_lo_s <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                     neg_hi_s <= is_signed & a[WIDTH-1];
                     dz_s     <= (b == '0);
                     a_s      <= a;
                  end else begin
                     out_valid <= 1'b1;
                     result    <= res_p0;
                     zero      <= (res_p0 == '0);
                     overflow  <= ovf_p0;
                  end
               end
            end
            ST_MUL, ST_DIV: begin
               if (md_done) begin
                  if (state == ST_MUL) begin
                     {hi, lo} <= prod_fix;
                  end else if (dz_s) begin
                     hi <= a_s;
                     lo <= DIVZERO_LO[WIDTH-1:0];
                  end else begin
                     hi <= apply_sign(md_hi, neg_hi_s);
                     lo <= apply_sign(md_lo, neg_lo_s);
                  end
                  state     <= ST_DONE;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  result    <= '0;
                  zero      <= 1'b1;
                  overflow  <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
